// File: rtl/arm7_prefetch.sv
// ARM7 instruction prefetch stage: fetches words from fetch_pc into a small
// {instr, pc} queue and presents them in order; a redirect flushes everything.
module arm7_prefetch #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DISCARD
  } state_e;

  state_e                 state_q, state_d;
  logic [31:0]            fetch_pc_q, fetch_pc_d;
  logic [31:0]            redirect_pc_q, redirect_pc_d;
  logic [CW-1:0]          count_q, count_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0][31:0] instr_q, instr_d;
  logic [DEPTH-1:0][31:0] pc_q, pc_d;

  logic          push;
  logic          pop;
  logic          has_room;
  logic [CW-1:0] count_next;
  logic [31:0]   flush_addr;

  assign mem_req   = (state_q == ST_REQ) || (state_q == ST_DISCARD);
  assign mem_addr  = fetch_pc_q;
  assign out_valid = (count_q != '0);
  assign out_instr = instr_q[rd_ptr_q];
  assign out_pc    = pc_q[rd_ptr_q];

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    redirect_pc_d = redirect_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    instr_d       = instr_q;
    pc_d          = pc_q;

    flush_addr = flush_pc & 32'hFFFF_FFFC;
    push       = mem_ack && (state_q == ST_REQ) && !flush;
    pop        = out_valid && out_ready && !flush;
    count_next = count_q + CW'(push) - CW'(pop);
    has_room   = (count_next < DEPTH_C);
    count_d    = count_next;

    if (push) begin
      instr_d[wr_ptr_q] = mem_rdata;
      pc_d[wr_ptr_q]    = fetch_pc_q;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (has_room) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (mem_ack) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = has_room ? ST_REQ : ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (mem_ack) begin
          fetch_pc_d = redirect_pc_q;
          state_d    = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A pending bus request cannot be withdrawn, so the new PC waits in
    // redirect_pc until the old transfer completes and is dropped.
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      if (mem_req && !mem_ack) begin
        state_d       = ST_DISCARD;
        fetch_pc_d    = fetch_pc_q;
        redirect_pc_d = flush_addr;
      end else begin
        state_d    = ST_REQ;
        fetch_pc_d = flush_addr;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      fetch_pc_q    <= RESET_PC;
      redirect_pc_q <= RESET_PC;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      instr_q       <= '0;
      pc_q          <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      redirect_pc_q <= redirect_pc_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      instr_q       <= instr_d;
      pc_q          <= pc_d;
    end
  end

endmodule
